// File: rtl/or1200_div_pkg.sv
// Shared state type, constants and helpers for the OR1200 serial divider.
package or1200_div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} div_state_t;

   // Helpers work at the widest supported operand size; callers truncate to their width.
   localparam int DIV_MAX_W = 64;

   localparam logic [DIV_MAX_W-1:0] DIV_DZ_QUOTIENT = '1;

   function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] value,
                                                    input logic                 is_signed);
      return (is_signed && value[DIV_MAX_W-1]) ? -value : value;
   endfunction

endpackage

// File: rtl/or1200_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, keep or restore.
module or1200_div_step
   import or1200_div_pkg::*;
#(
   parameter int width = 32
)(
   input  logic [width-1:0] rem,
   input  logic             dvd_msb,
   input  logic [width-1:0] dvs,
   output logic [width-1:0] rem_next,
   output logic             q_bit
);

   logic [width:0] partial;
   logic [width:0] diff;

   // The remainder is always below the divisor, so a set top bit of diff means "negative".
   always_comb begin
      partial  = {rem, dvd_msb};
      diff     = partial - {1'b0, dvs};
      q_bit    = ~diff[width];
      rem_next = q_bit ? diff[width-1:0] : partial[width-1:0];
   end

endmodule

// File: rtl/or1200_serial_div.sv
// Iterative radix-2 restoring divider for l.div / l.divu in the EX stage.
// Define OR1200_DIV_FAST_DZ_EN to complete divide-by-zero in one cycle.
module or1200_serial_div
   import or1200_div_pkg::*;
#(
   parameter int width = 32,
   parameter int CNT_W = 5
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_freeze,
   input  logic             start,
   input  logic             is_signed,
   input  logic             abort,
   input  logic [width-1:0] operand_a,
   input  logic [width-1:0] operand_b,
   output logic             div_stall,
   output logic [width-1:0] result,
   output logic             result_valid,
   output logic             ov_flag
);

   localparam int EXT = DIV_MAX_W - width;

   div_state_t       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [width-1:0] rem, dvd, dvs, quo;
   logic             neg_q, dz;
   logic             accept, b_zero;
   logic [width-1:0] abs_a, abs_b;
   logic [width-1:0] rem_next;
   logic             q_bit;

   assign b_zero = (operand_b == '0);
   assign abs_a  = width'(abs_val({{EXT{is_signed & operand_a[width-1]}}, operand_a}, is_signed));
   assign abs_b  = width'(abs_val({{EXT{is_signed & operand_b[width-1]}}, operand_b}, is_signed));

   or1200_div_step #(.width(width)) u_step (
      .rem      (rem),
      .dvd_msb  (dvd[width-1]),
      .dvs      (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      accept       = (state == IDLE) && start && !ex_freeze && !abort;
      div_stall    = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE: begin
            div_stall = accept;
            if (accept) begin
`ifdef OR1200_DIV_FAST_DZ_EN
               state_next = b_zero ? DONE : RUN;
`else
               state_next = RUN;
`endif
            end
         end
         RUN: begin
            div_stall = 1'b1;
            if (cnt == '0) state_next = FIXUP;
         end
         FIXUP: begin
            div_stall  = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            result_valid = 1'b1;
            if (!ex_freeze) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // A flush wins over everything, including a same-cycle start.
      if (abort) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rem     <= '0;
         dvd     <= '0;
         dvs     <= '0;
         quo     <= '0;
         neg_q   <= 1'b0;
         dz      <= 1'b0;
         result  <= '0;
         ov_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rem     <= '0;
                  dvd     <= abs_a;
                  dvs     <= abs_b;
                  quo     <= '0;
                  neg_q   <= is_signed & (operand_a[width-1] ^ operand_b[width-1]);
                  dz      <= b_zero;
                  cnt     <= CNT_W'(width - 1);
                  ov_flag <= 1'b0;
`ifdef OR1200_DIV_FAST_DZ_EN
                  if (b_zero) begin
                     result  <= width'(DIV_DZ_QUOTIENT);
                     ov_flag <= 1'b1;
                  end
`endif
               end
            end
            RUN: begin
               if (!abort) begin
                  rem <= rem_next;
                  dvd <= {dvd[width-2:0], 1'b0};
                  quo <= {quo[width-2:0], q_bit};
                  cnt <= cnt - CNT_W'(1);
               end
            end
            FIXUP: begin
               // An aborted operation must leave the previous result visible.
               if (!abort) begin
                  if (dz)         result <= width'(DIV_DZ_QUOTIENT);
                  else if (neg_q) result <= -quo;
                  else            result <= quo;
                  ov_flag <= dz;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_or1200_serial_div.sv
// Self-checking bench for or1200_serial_div against an arithmetic reference model.
// Honours OR1200_DIV_FAST_DZ_EN when predicting divide-by-zero latency.
module tb_or1200_serial_div;

   localparam int TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst, ex_freeze, start, is_signed, abort;
   logic [31:0] operand_a, operand_b;
   logic        div_stall, result_valid, ov_flag;
   logic [31:0] result;

   int          checks = 0;
   int          passed = 0;
   int          failed = 0;
   logic [31:0] last_q = '0;

   or1200_serial_div #(.width(32), .CNT_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_freeze    (ex_freeze),
      .start        (start),
      .is_signed    (is_signed),
      .abort        (abort),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .div_stall    (div_stall),
      .result       (result),
      .result_valid (result_valid),
      .ov_flag      (ov_flag)
   );

   always #5 clk = ~clk;

   // Quotient from plain integer arithmetic; 64-bit signed division makes the INT_MIN/-1 wrap natural.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] q, output logic ov);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
         q  = 32'hFFFF_FFFF;
         ov = 1'b1;
      end else if (s) begin
         q  = 32'(sa / sb);
         ov = 1'b0;
      end else begin
         q  = a / b;
         ov = 1'b0;
      end
   endfunction

   function automatic int ref_latency(input logic [31:0] b);
`ifdef OR1200_DIV_FAST_DZ_EN
      return (b == 32'd0) ? 1 : 34;
`else
      return 34;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      operand_a = a;
      operand_b = b;
      is_signed = s;
      start     = 1'b1;
   endtask

   // Counts cycles from the accept cycle (0) to the first result_valid, and stall cycles before it.
   task automatic waitResult(input int freeze_at, output int lat, output int stalls);
      lat    = 0;
      stalls = 0;
      #1;
      while (!result_valid && lat < TIMEOUT) begin
         if (div_stall) stalls++;
         @(negedge clk);
         lat++;
         if (lat == 1) start = 1'b0;
         if (lat == freeze_at) begin
            ex_freeze = 1'b1;
            start     = 1'b1;
            operand_a = 32'h1234_5678;
            operand_b = 32'd3;
         end
         #1;
      end
   endtask

   task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
      int          lat, stalls, exp_lat;
      logic [31:0] q;
      logic        ov;
      ref_div(a, b, s, q, ov);
      exp_lat = ref_latency(b);
      applyStimulus(a, b, s);
      waitResult(-1, lat, stalls);
      checkOutput({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "/stall_cycles"}, 32'(stalls), 32'(exp_lat));
      checkOutput({tag, "/result"}, result, q);
      checkOutput({tag, "/ov_flag"}, 32'(ov_flag), 32'(ov));
      checkOutput({tag, "/stall_in_done"}, 32'(div_stall), 32'd0);
      @(negedge clk);
      #1;
      checkOutput({tag, "/valid_drop"}, 32'(result_valid), 32'd0);
      checkOutput({tag, "/result_hold"}, result, q);
      last_q = q;
   endtask

   initial begin
      int          lat, stalls, valid_cnt, stray;
      logic [31:0] ra, rb, q;
      logic        rs, ov;

      rst = 1'b1; ex_freeze = 1'b0; start = 1'b0; is_signed = 1'b0; abort = 1'b0;
      operand_a = '0; operand_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset/result", result, 32'd0);
      checkOutput("reset/valid", 32'(result_valid), 32'd0);
      checkOutput("reset/ov_flag", 32'(ov_flag), 32'd0);
      checkOutput("reset/stall", 32'(div_stall), 32'd0);

      doOp("udiv_100_7", 32'd100, 32'd7, 1'b0);
      doOp("sdiv_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
      doOp("sdiv_intmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      doOp("div_by_zero", 32'd5, 32'd0, 1'b0);
      doOp("udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i == 5) rb = 32'd0;
         rs = 1'($urandom_range(0, 1));
         if (rs && i % 3 == 0) rb = -rb;
         doOp($sformatf("random%0d", i), ra, rb, rs);
      end

      // Abort in the middle of RUN; a start right afterwards must still be taken.
      applyStimulus(32'd1000, 32'd3, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      checkOutput("abort/valid", 32'(result_valid), 32'd0);
      checkOutput("abort/stall", 32'(div_stall), 32'd0);
      checkOutput("abort/result_kept", result, last_q);
      doOp("after_abort", 32'd1000, 32'd3, 1'b0);

      // Freeze raised mid-RUN (no effect there) with a stray start, held for 3 cycles of DONE.
      ref_div(32'd1000, 32'd7, 1'b0, q, ov);
      applyStimulus(32'd1000, 32'd7, 1'b0);
      waitResult(5, lat, stalls);
      start = 1'b0;
      checkOutput("freeze/latency", 32'(lat), 32'd34);
      checkOutput("freeze/stall_cycles", 32'(stalls), 32'd34);
      checkOutput("freeze/result", result, q);
      valid_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (result_valid) valid_cnt++;
         if (i == 3) ex_freeze = 1'b0;
         @(negedge clk);
         #1;
      end
      checkOutput("freeze/valid_cycles", 32'(valid_cnt), 32'd4);
      checkOutput("freeze/idle_stall", 32'(div_stall), 32'd0);
      checkOutput("freeze/result_hold", result, q);
      last_q = q;

      // Synchronous reset in RUN discards the operation.
      applyStimulus(32'd77, 32'd5, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_run/result", result, 32'd0);
      checkOutput("rst_run/valid", 32'(result_valid), 32'd0);
      checkOutput("rst_run/ov_flag", 32'(ov_flag), 32'd0);
      checkOutput("rst_run/stall", 32'(div_stall), 32'd0);
      stray = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (result_valid) stray++;
      end
      checkOutput("rst_run/no_valid_after", 32'(stray), 32'd0);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/or1200_serial_div.md
Name: or1200_serial_div

Overview:
- Iterative radix-2 restoring divider in the EX stage, directly downstream of the operand-mux stage.
- Consumes the registered operands (operand_a = dividend, operand_b = divisor) when a divide instruction issues.
- Raises div_stall so the pipeline-freeze logic holds the pipeline, then returns a 32-bit quotient with a one-cycle valid strobe to the writeback result mux.
- Implements l.div and l.divu.

Parameters:
- width, 32, operand and quotient width in bits; must be even and at least 4.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ex_freeze  in  1  EX stage frozen by a downstream stall.
- start  in  1  a divide instruction is in EX with valid operands.
- is_signed  in  1  1 = l.div (two's complement), 0 = l.divu.
- abort  in  1  pipeline flush (exception or branch); kills any operation in progress.
- operand_a  in  width  dividend.
- operand_b  in  width  divisor.
- div_stall  out  1  request to freeze the pipeline.
- result  out  width  quotient.
- result_valid  out  1  result is valid this cycle.
- ov_flag  out  1  divide-by-zero indication, valid with result_valid.

Behaviour:
- Reset: rst=1 at a clock edge forces state=IDLE and clears result, result_valid, ov_flag, div_stall, counter, and all datapath registers. Reset mid-operation discards the operation with no result_valid.
- States: IDLE, RUN, FIXUP, DONE.
- Accept: start && !ex_freeze && !abort in IDLE.
  - Latch |a| and |b| (absolute values only when is_signed=1).
  - Latch neg_q = is_signed & (a[msb] ^ b[msb]).
  - Latch dz = (b == 0).
  - Counter loads width-1. Go to RUN.
- start while not in IDLE is ignored.
- div_stall is combinational: (IDLE && accept) || RUN || FIXUP. It is never asserted in DONE.
- RUN, one quotient bit per cycle:
  - partial remainder = {rem, dividend msb}; subtract divisor; if the result is non-negative, keep it and shift in 1, else shift in 0.
  - When the counter reaches 0, go to FIXUP. RUN lasts exactly width cycles.
- FIXUP:
  - If neg_q, negate the quotient (two's complement, width bits, wraps).
  - If dz, force quotient = all ones and ov_flag = 1.
  - Go to DONE.
- DONE: result_valid=1.
  - If ex_freeze=1, stay in DONE with result_valid held.
  - Otherwise return to IDLE next cycle.
- Latency: accept at cycle 0, result_valid at cycle width+2 (34 for width=32).
- result holds its value in IDLE until the next accept.
- ex_freeze during RUN or FIXUP has no effect; iteration continues.
- abort in any state: go to IDLE next cycle, result_valid=0, result unchanged. abort takes priority over start in the same cycle.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) with ov_flag=0.
- Only the quotient is produced; the remainder is internal.

Optional Feature:
- Macro: OR1200_DIV_FAST_DZ_EN.
- When defined, an accept with divisor == 0 skips RUN and FIXUP: IDLE goes straight to DONE, result_valid appears at cycle 1 with result=0xFFFFFFFF and ov_flag=1. div_stall is asserted only in the accept cycle.
- When undefined, divide-by-zero takes the full width+2 cycles with the same result and flag.

Decomposition:
- Shared package or1200_div_pkg:
  - state enum (IDLE, RUN, FIXUP, DONE);
  - DIV_DZ_QUOTIENT constant (all ones);
  - function abs_val(value, is_signed).
- One sub-module, or1200_div_step: the combinational single-iteration subtract/compare/shift, instanced once per cycle in RUN.

Test Plan:
- Unsigned: a=100, b=7, is_signed=0 -> result_valid at cycle 34, result=14, ov_flag=0, div_stall high for cycles 0-33.
- Signed negative: a=0xFFFFFF9C (-100), b=7, is_signed=1 -> result=0xFFFFFFF2 (-14); signed edge case 0x80000000/0xFFFFFFFF -> 0x80000000, ov_flag=0.
- Divide-by-zero: a=5, b=0 -> result=0xFFFFFFFF, ov_flag=1, at cycle 34 with the macro undefined and cycle 1 with it defined.
- Abort: assert abort at cycle 10 of RUN -> IDLE at cycle 11, no result_valid, div_stall low, previous result unchanged; a new start at cycle 12 is accepted.
- Freeze in DONE: hold ex_freeze=1 for 3 cycles at completion -> result_valid stays high for 4 cycles, then drops; start asserted during RUN is ignored.
- Reset in RUN: rst=1 at cycle 5 -> all outputs 0 next cycle, state IDLE, no result_valid afterwards.
